// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and types for the SPI flash read path
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         CMD_BITS   = 8;
  localparam int         ADDR_BITS  = 24;
  localparam int         DATA_BITS  = 32;
  localparam int         FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  // Bytes arrive first-byte-first; the first byte belongs in the low lane.
  function automatic logic [DATA_BITS-1:0] le_word(input logic [DATA_BITS-1:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// rtl/spi_bit_engine.sv - SCK divider plus 64-bit MOSI/MISO shifter for one READ frame
// start loads the frame; done marks the edge that completes the 64th SCK fall.
module spi_bit_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic                 done,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [6:0]  BIT_LAST = 7'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic [15:0]           div_q, div_d;
  logic                  sck_q, sck_d;
  logic [6:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0]  rx_q, rx_d;
  logic                  done_c;
  logic                  tick;

  assign tick = active_q && (div_q == DIV_LAST);

  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    sck_d    = sck_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    done_c   = 1'b0;
    if (start) begin
      active_d = 1'b1;
      div_d    = '0;
      sck_d    = 1'b0;
      bit_d    = '0;
      tx_d     = {CMD_READ, addr, {DATA_BITS{1'b0}}};
    end else if (active_q) begin
      if (tick) begin
        div_d = '0;
        sck_d = ~sck_q;
        if (!sck_q) begin
          // Sample in the cycle SCK rises; only the final 32 samples survive.
          rx_d = {rx_q[DATA_BITS-2:0], miso};
        end else begin
          // Zeros shift in behind the header, so MOSI idles low afterwards.
          tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
          bit_d = bit_q + 7'd1;
          if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
            done_c   = 1'b1;
          end
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      sck_q    <= 1'b0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      sck_q    <= sck_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = tx_q[FRAME_BITS-1];
  assign done    = done_c;
  assign rx_data = rx_q;

endmodule

// File: rtl/spi_flash_read_arbiter.sv
// rtl/spi_flash_read_arbiter.sv - round-robin share of the boot SPI NOR between fetch and data ports
// One READ (0x03) word per grant; arbitration only happens in IDLE.
module spi_flash_read_arbiter
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [24:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [24:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        busy,
  output logic [1:0]  spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [15:0] HOLD_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        port_q, port_d;
  logic [1:0]  cs_q, cs_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic                 grant0;
  logic                 grant1;
  logic                 start;
  logic [24:0]          sel_addr;
  logic                 eng_done;
  logic [DATA_BITS-1:0] eng_rx;

  // last_q == 1 means port 1 was served last, so port 0 has priority.
  assign grant0   = m0_req && (!m1_req || last_q);
  assign grant1   = m1_req && !grant0;
  assign start    = (state_q == IDLE) && (grant0 || grant1);
  assign sel_addr = grant0 ? m0_addr : m1_addr;

  spi_bit_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (sel_addr[ADDR_BITS-1:0]),
    .miso    (spi_miso),
    .sck     (spi_clk),
    .mosi    (spi_mosi),
    .done    (eng_done),
    .rx_data (eng_rx)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    cs_d       = cs_q;
    cnt_d      = cnt_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          port_d  = grant1;
          last_d  = grant1;
          cs_d    = sel_addr[24] ? 2'b01 : 2'b10;
        end
      end
      SHIFT: begin
        if (eng_done) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          cs_d    = 2'b11;
          if (port_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = le_word(eng_rx);
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = le_word(eng_rx);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      port_q     <= 1'b0;
      cs_q       <= 2'b11;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      port_q     <= port_d;
      cs_q       <= cs_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign spi_cs   = cs_q;
  assign busy     = busy_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// tb/tb_spi_flash_read_arbiter.sv - directed bench with a behavioural N25Q-style flash per DUT
module tb_spi_flash_read_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [24:0] m0_addr = '0, m1_addr = '0;
  logic        m0_ready, m1_ready, busy;
  logic [31:0] m0_rdata, m1_rdata;

  logic        f_m0_req = 1'b0, f_m1_req = 1'b0;
  logic [24:0] f_m0_addr = '0, f_m1_addr = '0;
  logic        f_m0_ready, f_m1_ready, f_busy;
  logic [31:0] f_m0_rdata, f_m1_rdata;

  logic [1:0] cs_w   [2];
  logic       sck_w  [2];
  logic       mosi_w [2];
  logic       miso_w [2] = '{1'b0, 1'b0};

  spi_flash_read_arbiter #(.CLK_DIV(2), .CS_GAP(4)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .busy(busy), .spi_cs(cs_w[0]), .spi_clk(sck_w[0]), .spi_mosi(mosi_w[0]), .spi_miso(miso_w[0])
  );

  spi_flash_read_arbiter #(.CLK_DIV(1), .CS_GAP(1)) u_fast (
    .clk(clk), .rst(rst),
    .m0_req(f_m0_req), .m0_addr(f_m0_addr), .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata),
    .m1_req(f_m1_req), .m1_addr(f_m1_addr), .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
    .busy(f_busy), .spi_cs(cs_w[1]), .spi_clk(sck_w[1]), .spi_mosi(mosi_w[1]), .spi_miso(miso_w[1])
  );

  // Flash contents: chip 0 holds 11 22 33 44 at 0x10; elsewhere a simple address pattern.
  function automatic logic [7:0] fbyte(input logic chip, input logic [23:0] a);
    if (!chip && a >= 24'h10 && a <= 24'h13) return 8'h11 * (a[7:0] - 8'h0F);
    return a[7:0] + 8'h40 + (chip ? 8'h80 : 8'h00);
  endfunction

  int          fcnt    [2] = '{0, 0};
  logic [31:0] fhdr    [2] = '{32'h0, 32'h0};
  logic [31:0] hdr_log [2] = '{32'h0, 32'h0};
  logic        fprev   [2] = '{1'b0, 1'b0};

  always @(sck_w[0] or cs_w[0] or sck_w[1] or cs_w[1]) begin : flash_model
    int k;
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      if (cs_w[i] == 2'b11) begin
        fcnt[i]   = 0;
        miso_w[i] = 1'b0;
      end else if (sck_w[i] === 1'b1 && fprev[i] === 1'b0) begin
        if (fcnt[i] < 32) fhdr[i] = {fhdr[i][30:0], mosi_w[i]};
        fcnt[i] = fcnt[i] + 1;
        if (fcnt[i] == 32) hdr_log[i] = fhdr[i];
      end else if (sck_w[i] === 1'b0 && fprev[i] === 1'b1) begin
        if (fcnt[i] >= 32 && fcnt[i] < 64) begin
          k = fcnt[i] - 32;
          b = fbyte(cs_w[i] == 2'b01, fhdr[i][23:0] + 24'(k / 8));
          miso_w[i] = b[7 - (k % 8)];
        end
      end
      fprev[i] = sck_w[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  task automatic do_read(input bit port, input logic [24:0] addr, output int lat,
                         output logic [31:0] data, output logic [1:0] cs_and,
                         output logic [1:0] cs_or, output int other_rdy, output bit timeout);
    if (port) begin m1_addr = addr; m1_req = 1'b1; end
    else      begin m0_addr = addr; m0_req = 1'b1; end
    lat = 0; data = '0; cs_and = 2'b11; cs_or = 2'b00; other_rdy = 0; timeout = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      if (port ? m1_ready : m0_ready) begin
        lat = c; data = port ? m1_rdata : m0_rdata; timeout = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        break;
      end
      cs_and = cs_and & cs_w[0];
      cs_or  = cs_or | cs_w[0];
      if (port ? m0_ready : m1_ready) other_rdy++;
    end
  endtask

  typedef struct {
    bit          port;
    logic [24:0] addr;
    logic [1:0]  exp_cs;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [5];
  logic [31:0] exp_rd [2];

  initial begin : main
    int lat, oth, n, hi_run, gaps, gmin, gmax, nrst, t0, t1, nr, f_other;
    logic [31:0] data, d0, d1;
    logic [1:0] cand, cor;
    bit tmo;
    int order [4];

    vecs[0] = '{1'b0, 25'h0000010, 2'b10, 32'h44332211};
    vecs[1] = '{1'b1, 25'h1000000, 2'b01, 32'hC3C2C1C0};
    vecs[2] = '{1'b0, 25'h0000100, 2'b10, 32'h43424140};
    vecs[3] = '{1'b1, 25'h0000012, 2'b10, 32'h55544433};
    vecs[4] = '{1'b0, 25'h1ABCDEF, 2'b01, 32'hB2B1B0AF};
    exp_rd[0] = '0; exp_rd[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs_w[0], 2'b11);
    check("rst_sck", sck_w[0], 0);
    check("rst_mosi", mosi_w[0], 0);
    check("rst_ready", {m1_ready, m0_ready}, 0);
    check("rst_rdata", {m1_rdata, m0_rdata}, 0);
    check("rst_busy", busy, 0);
    check("rst_fast_cs", cs_w[1], 2'b11);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      do_read(vecs[v].port, vecs[v].addr, lat, data, cand, cor, oth, tmo);
      check($sformatf("v%0d_timeout", v), tmo, 0);
      check($sformatf("v%0d_latency", v), lat, 259);
      check($sformatf("v%0d_rdata", v), data, vecs[v].exp_data);
      check($sformatf("v%0d_cs_and", v), cand, vecs[v].exp_cs);
      check($sformatf("v%0d_cs_or", v), cor, vecs[v].exp_cs);
      check($sformatf("v%0d_other_ready", v), oth, 0);
      check($sformatf("v%0d_mosi_hdr", v), hdr_log[0], {8'h03, vecs[v].addr[23:0]});
      exp_rd[vecs[v].port] = vecs[v].exp_data;
      wait_idle();
      check($sformatf("v%0d_m0_hold", v), m0_rdata, exp_rd[0]);
      check($sformatf("v%0d_m1_hold", v), m1_rdata, exp_rd[1]);
      check($sformatf("v%0d_mosi_idle", v), mosi_w[0], 0);
    end

    // Simultaneous requests after reset, both held: expect 0,1,0,1.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    m0_addr = 25'h0000010; m1_addr = 25'h1000000;
    m0_req = 1'b1; m1_req = 1'b1;
    n = 0; hi_run = 0; gaps = 0; gmin = 9999; gmax = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int c = 0; c < 3000 && n < 4; c++) begin
      @(posedge clk); #1;
      if (cs_w[0] == 2'b11) hi_run++;
      else begin
        if (n > 0 && hi_run > 0) begin
          gaps++;
          if (hi_run < gmin) gmin = hi_run;
          if (hi_run > gmax) gmax = hi_run;
        end
        hi_run = 0;
      end
      if (m0_ready) begin order[n] = 0; check("sim_m0_rdata", m0_rdata, 32'h44332211); n++; end
      if (m1_ready) begin order[n] = 1; check("sim_m1_rdata", m1_rdata, 32'hC3C2C1C0); n++; end
      if (n >= 4) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("sim_count", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("sim_order%0d", i), order[i], i % 2);
    check("sim_gaps", gaps, 3);
    check("sim_gap_min", gmin, 5);
    check("sim_gap_max", gmax, 5);
    wait_idle();

    // Reset in the middle of a transfer, request held throughout.
    m0_addr = 25'h0000100; m0_req = 1'b1; nrst = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (m0_ready) nrst++;
    end
    check("mid_cs_before", cs_w[0], 2'b10);
    check("mid_sck_before", sck_w[0], 1);
    rst = 1'b1;
    #1;
    check("mid_cs_async", cs_w[0], 2'b11);
    check("mid_sck_async", sck_w[0], 0);
    check("mid_busy_async", busy, 0);
    repeat (3) begin
      @(posedge clk); #1;
      if (m0_ready) nrst++;
    end
    check("mid_no_ready", nrst, 0);
    rst = 1'b0;
    do_read(1'b0, 25'h0000100, lat, data, cand, cor, oth, tmo);
    check("mid_timeout", tmo, 0);
    check("mid_latency", lat, 259);
    check("mid_rdata", data, 32'h43424140);
    wait_idle();

    // Fast clock: back-to-back port 0 reads on the CLK_DIV=1, CS_GAP=1 instance.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    f_m0_addr = 25'h0; f_m0_req = 1'b1;
    nr = 0; t0 = 0; t1 = 0; d0 = '0; d1 = '0; f_other = 0;
    for (int c = 1; c <= 600 && nr < 2; c++) begin
      @(posedge clk); #1;
      if (f_m1_ready) f_other++;
      if (f_m0_ready) begin
        if (nr == 0) begin t0 = c; d0 = f_m0_rdata; f_m0_addr = 25'h4; end
        else begin t1 = c; d1 = f_m0_rdata; f_m0_req = 1'b0; end
        nr++;
      end
    end
    f_m0_req = 1'b0;
    check("fast_count", nr, 2);
    check("fast_first_cycle", t0, 130);
    check("fast_spacing", t1 - t0, 131);
    check("fast_rdata0", d0, 32'h43424140);
    check("fast_rdata1", d1, 32'h47464544);
    check("fast_m1_ready", f_other, 0);
    check("fast_mosi_hdr", hdr_log[1], {8'h03, 24'h000004});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
